// File: rtl/id_ex_stage_if.sv
// Bundle of decode-side inputs, writeback bypass inputs and ID/EX outputs for id_ex_stage.
// The master side drives decode and writeback; the slave side is the pipeline register.
interface id_ex_stage_if #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [31:0]       id_pc;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic [31:0]       id_rs_data;
    logic [31:0]       id_rt_data;
    logic [31:0]       id_imm;
    logic              id_reg_dst;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic [CTRL_W-1:0] id_ctrl;
    logic              wb_reg_write;
    logic [4:0]        wb_write_reg;
    logic [31:0]       wb_write_data;
    logic              flush;
    logic              hold;
    logic              stall_out;
    logic              ex_valid;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic [31:0]       ex_pc;
    logic [31:0]       ex_imm;
    logic [31:0]       ex_rs_data;
    logic [31:0]       ex_rt_data;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_dest;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output id_valid, id_pc, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
               id_rs_data, id_rt_data, id_imm, id_reg_dst, id_reg_write,
               id_mem_read, id_mem_write, id_ctrl,
               wb_reg_write, wb_write_reg, wb_write_data, flush, hold,
        input  stall_out, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_pc, ex_imm, ex_rs_data, ex_rt_data, ex_rs, ex_rt, ex_dest,
               ex_ctrl, bubble_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
               id_rs_data, id_rt_data, id_imm, id_reg_dst, id_reg_write,
               id_mem_read, id_mem_write, id_ctrl,
               wb_reg_write, wb_write_reg, wb_write_data, flush, hold,
        output stall_out, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_pc, ex_imm, ex_rs_data, ex_rt_data, ex_rs, ex_rt, ex_dest,
               ex_ctrl, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB write-through bypass, load-use bubble insertion,
// flush/hold handling and a saturating bubble counter.
module id_ex_stage #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);
    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [31:0]       pc;
        logic [31:0]       imm;
        logic [31:0]       rs_data;
        logic [31:0]       rt_data;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        dest;
        logic [CTRL_W-1:0] ctrl;
    } ex_t;

    ex_t              ex_q, ex_d, ex_load;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bubble;
    logic             load_use;

    logic [4:0]  src_reg  [2];
    logic [31:0] src_data [2];
    logic [31:0] src_cap  [2];

    assign src_reg[0]  = bus.id_rs;
    assign src_reg[1]  = bus.id_rt;
    assign src_data[0] = bus.id_rs_data;
    assign src_data[1] = bus.id_rt_data;

    // The register file writes at the edge but reads before it, so a same-cycle
    // WB write must be forwarded here; $0 always reads as zero.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
        assign src_cap[gi] = (src_reg[gi] == 5'd0) ? 32'd0 :
                             (bus.wb_reg_write && bus.wb_write_reg != 5'd0 &&
                              bus.wb_write_reg == src_reg[gi]) ? bus.wb_write_data :
                             src_data[gi];
    end

    assign load_use = bus.id_valid && ex_q.valid && ex_q.mem_read && (ex_q.dest != 5'd0) &&
                      ((bus.id_uses_rs && bus.id_rs == ex_q.dest) ||
                       (bus.id_uses_rt && bus.id_rt == ex_q.dest));

    assign bus.stall_out = bus.hold || (load_use && !bus.flush);

    always_comb begin
        ex_load.valid     = bus.id_valid;
        ex_load.reg_write = bus.id_reg_write & bus.id_valid;
        ex_load.mem_read  = bus.id_mem_read  & bus.id_valid;
        ex_load.mem_write = bus.id_mem_write & bus.id_valid;
        ex_load.pc        = bus.id_pc;
        ex_load.imm       = bus.id_imm;
        ex_load.rs_data   = src_cap[0];
        ex_load.rt_data   = src_cap[1];
        ex_load.rs        = bus.id_rs;
        ex_load.rt        = bus.id_rt;
        ex_load.dest      = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
        ex_load.ctrl      = bus.id_ctrl & {CTRL_W{bus.id_valid}};
    end

    always_comb begin
        ex_d   = ex_q;
        bubble = 1'b0;
        if (bus.flush) begin
            ex_d   = '0;
            bubble = bus.id_valid;
        end else if (bus.hold) begin
            ex_d   = ex_q;
        end else if (load_use) begin
            ex_d   = '0;
            bubble = 1'b1;
        end else begin
            ex_d   = ex_load;
        end
        cnt_d = (bubble && cnt_q != {CNT_W{1'b1}}) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_reg_write = ex_q.reg_write;
    assign bus.ex_mem_read  = ex_q.mem_read;
    assign bus.ex_mem_write = ex_q.mem_write;
    assign bus.ex_pc        = ex_q.pc;
    assign bus.ex_imm       = ex_q.imm;
    assign bus.ex_rs_data   = ex_q.rs_data;
    assign bus.ex_rt_data   = ex_q.rt_data;
    assign bus.ex_rs        = ex_q.rs;
    assign bus.ex_rt        = ex_q.rt;
    assign bus.ex_dest      = ex_q.dest;
    assign bus.ex_ctrl      = ex_q.ctrl;
    assign bus.bubble_cnt   = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: stimulus pushes expected results, a monitor pops and compares.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_ex_stage_if #(.CTRL_W(8), .CNT_W(16)) bus ();
    id_ex_stage #(.CTRL_W(8), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        string       name;
        logic        stall;
        logic        valid;
        logic        mr;
        logic [31:0] pc;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [4:0]  dest;
        logic [7:0]  ctrl;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int compared   = 0;
    int mismatched = 0;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, want);
        end
    endtask

    // Stall is sampled just before the edge, registered outputs just after it.
    initial begin
        logic st;
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            st = bus.stall_out;
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                $display("txn %-12s stall=%0b valid=%0b mr=%0b pc=%h rs=%h rt=%h dest=%0d cnt=%h",
                         e.name, st, bus.ex_valid, bus.ex_mem_read, bus.ex_pc,
                         bus.ex_rs_data, bus.ex_rt_data, bus.ex_dest, bus.bubble_cnt);
                cmp(e.name, "stall_out",  {31'd0, st},              {31'd0, e.stall});
                cmp(e.name, "ex_valid",   {31'd0, bus.ex_valid},    {31'd0, e.valid});
                cmp(e.name, "ex_mem_read",{31'd0, bus.ex_mem_read}, {31'd0, e.mr});
                cmp(e.name, "ex_pc",      bus.ex_pc,                e.pc);
                cmp(e.name, "ex_rs_data", bus.ex_rs_data,           e.rsd);
                cmp(e.name, "ex_rt_data", bus.ex_rt_data,           e.rtd);
                cmp(e.name, "ex_dest",    {27'd0, bus.ex_dest},     {27'd0, e.dest});
                cmp(e.name, "ex_ctrl",    {24'd0, bus.ex_ctrl},     {24'd0, e.ctrl});
                cmp(e.name, "bubble_cnt", {16'd0, bus.bubble_cnt},  {16'd0, e.cnt});
            end
        end
    end

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic urs, input logic urt,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic rdst,
                          input logic rw, input logic mr);
        bus.id_valid     = v;
        bus.id_pc        = pc;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_rd        = rd;
        bus.id_uses_rs   = urs;
        bus.id_uses_rt   = urt;
        bus.id_rs_data   = rsd;
        bus.id_rt_data   = rtd;
        bus.id_imm       = 32'hFFFF_FFF0;
        bus.id_reg_dst   = rdst;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.id_mem_write = 1'b0;
        bus.id_ctrl      = 8'hC3;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] r, input logic [31:0] d);
        bus.wb_reg_write  = en;
        bus.wb_write_reg  = r;
        bus.wb_write_data = d;
    endtask

    task automatic push_exp(input string nm, input logic st, input logic v, input logic mr,
                            input logic [31:0] pc, input logic [31:0] rsd, input logic [31:0] rtd,
                            input logic [4:0] dest, input logic [15:0] cnt);
        exp_t e;
        e.name = nm; e.stall = st; e.valid = v; e.mr = mr; e.pc = pc;
        e.rsd = rsd; e.rtd = rtd; e.dest = dest; e.cnt = cnt;
        e.ctrl = v ? 8'hC3 : 8'h00;
        q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.hold  = 1'b0;
        set_wb(1'b0, 5'd0, 32'd0);
        set_id(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);

        // Reset with scrambled decode inputs
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_id(1'b1, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1,
                   $urandom, $urandom, 1'($urandom), 1'b1, 1'($urandom));
            bus.id_ctrl = 8'($urandom);
            bus.flush   = 1'($urandom);
            set_wb(1'b1, 5'($urandom), $urandom);
            push_exp("reset", 0, 0, 0, 0, 0, 0, 0, 16'h0);
        end

        @(negedge clk); rst_n = 1'b1; bus.flush = 1'b0; set_wb(1'b0, 5'd0, 32'd0);
        set_id(1, 32'h100, 2, 3, 5, 1, 1, 32'h11, 32'h22, 1, 1, 0);
        push_exp("plain", 0, 1, 0, 32'h100, 32'h11, 32'h22, 5, 0);

        @(negedge clk); set_wb(1, 3, 32'hABCD_EF12);
        set_id(1, 32'h104, 3, 6, 0, 1, 1, 32'h0, 32'h66, 0, 1, 0);
        push_exp("wb_rs", 0, 1, 0, 32'h104, 32'hABCD_EF12, 32'h66, 6, 0);

        @(negedge clk); set_wb(1, 0, 32'h77);
        set_id(1, 32'h108, 0, 9, 0, 1, 1, 32'h55, 32'h99, 0, 1, 0);
        push_exp("wb_zero", 0, 1, 0, 32'h108, 32'h0, 32'h99, 9, 0);

        @(negedge clk); set_wb(1, 8, 32'hCAFE_0008);
        set_id(1, 32'h10C, 7, 8, 0, 1, 1, 32'h99, 32'h88, 0, 1, 0);
        push_exp("wb_rt", 0, 1, 0, 32'h10C, 32'h99, 32'hCAFE_0008, 8, 0);

        @(negedge clk); set_wb(0, 0, 0);
        set_id(1, 32'h200, 1, 4, 0, 1, 0, 32'h1000, 32'h0, 0, 1, 1);
        push_exp("lw1", 0, 1, 1, 32'h200, 32'h1000, 32'h0, 4, 0);

        @(negedge clk);
        set_id(1, 32'h204, 4, 5, 6, 1, 1, 32'h4444, 32'h55, 1, 1, 0);
        push_exp("lu_bubble", 1, 0, 0, 0, 0, 0, 0, 1);

        @(negedge clk);
        push_exp("lu_release", 0, 1, 0, 32'h204, 32'h4444, 32'h55, 6, 1);

        @(negedge clk);
        set_id(1, 32'h300, 1, 4, 0, 1, 0, 32'h2000, 32'h0, 0, 1, 1);
        push_exp("lw2", 0, 1, 1, 32'h300, 32'h2000, 32'h0, 4, 1);

        @(negedge clk);
        set_id(1, 32'h204, 4, 5, 6, 0, 1, 32'h4444, 32'h55, 1, 1, 0);
        push_exp("no_use_rs", 0, 1, 0, 32'h204, 32'h4444, 32'h55, 6, 1);

        @(negedge clk);
        set_id(1, 32'h400, 1, 0, 0, 1, 0, 32'h10, 32'hDEAD, 0, 1, 1);
        push_exp("lw_r0", 0, 1, 1, 32'h400, 32'h10, 32'h0, 0, 1);

        @(negedge clk);
        set_id(1, 32'h404, 0, 2, 3, 1, 1, 32'h1234, 32'h22, 1, 1, 0);
        push_exp("r0_nostall", 0, 1, 0, 32'h404, 32'h0, 32'h22, 3, 1);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk); bus.hold = 1'b1;
            set_id(1, 32'h500 + 32'(i * 4), 2, 3, 7, 1, 1, $urandom, $urandom, 1, 1, 1);
            push_exp("hold", 1, 1, 0, 32'h404, 32'h0, 32'h22, 3, 1);
        end

        @(negedge clk); bus.hold = 1'b0;
        set_id(1, 32'h508, 2, 3, 7, 1, 1, 32'h5, 32'h6, 1, 1, 0);
        push_exp("hold_rel", 0, 1, 0, 32'h508, 32'h5, 32'h6, 7, 1);

        @(negedge clk); bus.flush = 1'b1; bus.hold = 1'b1;
        set_id(1, 32'h600, 2, 3, 7, 1, 1, 32'h5, 32'h6, 1, 1, 0);
        push_exp("flush_hold", 1, 0, 0, 0, 0, 0, 0, 2);

        @(negedge clk); bus.hold = 1'b0;
        set_id(0, 32'h604, 2, 3, 7, 1, 1, 32'h5, 32'h6, 1, 1, 0);
        push_exp("flush_inv", 0, 0, 0, 0, 0, 0, 0, 2);

        @(negedge clk); bus.flush = 1'b0;
        set_id(1, 32'h700, 1, 4, 0, 1, 0, 32'h3000, 32'h0, 0, 1, 1);
        push_exp("lw3", 0, 1, 1, 32'h700, 32'h3000, 32'h0, 4, 2);

        @(negedge clk); bus.flush = 1'b1;
        set_id(1, 32'h704, 4, 5, 6, 1, 1, 32'h4444, 32'h55, 1, 1, 0);
        push_exp("flush_lu", 0, 0, 0, 0, 0, 0, 0, 3);

        @(negedge clk); bus.flush = 1'b0;
        set_id(1, 32'h800, 1, 4, 0, 1, 0, 32'h3000, 32'h0, 0, 1, 1);
        push_exp("lw4", 0, 1, 1, 32'h800, 32'h3000, 32'h0, 4, 3);

        @(negedge clk); rst_n = 1'b0;
        set_id(1, 32'h804, 4, 5, 6, 1, 1, 32'h4444, 32'h55, 1, 1, 0);
        push_exp("rst_stall", 1, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk); rst_n = 1'b1;
        push_exp("post_rst", 0, 1, 0, 32'h804, 32'h4444, 32'h55, 6, 0);

        // Drive flushes of valid instructions past the counter's full range
        for (int i = 1; i <= 65539; i++) begin
            @(negedge clk); bus.flush = 1'b1;
            if (i == 65534) push_exp("sat_m1",  0, 0, 0, 0, 0, 0, 0, 16'hFFFE);
            if (i == 65535) push_exp("sat_max", 0, 0, 0, 0, 0, 0, 0, 16'hFFFF);
            if (i == 65539) push_exp("sat_hold",0, 0, 0, 0, 0, 0, 0, 16'hFFFF);
        end

        @(negedge clk); bus.flush = 1'b0;
        for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expected items left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage sitting directly downstream of the register file in the 5-stage MIPS pipeline.
- Captures the register file read data, decoded fields and control into the ID/EX pipeline register.
- Applies a WB-to-ID write-through bypass, detects load-use hazards and inserts bubbles.
- Honours flush and downstream hold, and keeps a saturating bubble counter for performance monitoring.

Parameters:
- CTRL_W, 8, width of the opaque EX/MEM control bundle passed through unchanged.
- CNT_W, 16, width of the bubble performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_pc  in  32  PC of the decode instruction.
- id_rs, id_rt, id_rd  in  5 each  decoded register fields.
- id_uses_rs, id_uses_rt  in  1 each  instruction actually reads rs / rt.
- id_rs_data, id_rt_data  in  32 each  register file read ports.
- id_imm  in  32  sign-extended immediate.
- id_reg_dst  in  1  1: dest=rd, 0: dest=rt.
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits.
- id_ctrl  in  CTRL_W  opaque control bundle.
- wb_reg_write  in  1  WB writeback enable (same signal that drives RegWrite).
- wb_write_reg  in  5  WB destination.
- wb_write_data  in  32  WB data.
- flush  in  1  kill the decode instruction (branch or jump taken).
- hold  in  1  downstream stall; freeze the ID/EX register.
- stall_out  out  1  freeze PC and IF/ID this cycle.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1 each.
- ex_pc, ex_imm, ex_rs_data, ex_rt_data  out  32 each.
- ex_rs, ex_rt, ex_dest  out  5 each.
- ex_ctrl  out  CTRL_W.
- bubble_cnt  out  CNT_W  count of bubbles inserted.

Behaviour:
- All ex_* outputs are registered and update only on the rising edge of clk.
- Reset (rst_n=0 at an edge): every ex_* output goes to 0 and bubble_cnt goes to 0. stall_out is combinational and also reads 0 while ex_valid=0.
- Bypass, combinational:
  - rs_cap = wb_write_data when wb_reg_write && wb_write_reg!=0 && wb_write_reg==id_rs; otherwise id_rs_data. rt_cap is formed the same way from id_rt.
  - When id_rs==0, rs_cap is forced to 0; likewise rt_cap when id_rt==0.
  - This covers the register file's write-at-edge, read-after-delay behaviour in the same cycle.
- dest = id_reg_dst ? id_rd : id_rt.
- load_use = id_valid && ex_valid && ex_mem_read && ex_dest!=0 && ((id_uses_rs && id_rs==ex_dest) || (id_uses_rt && id_rt==ex_dest)).
- stall_out = hold || (load_use && !flush). It is combinational with zero-cycle latency.
- Per-edge priority, highest first:
  - 1. Reset.
  - 2. flush: bubble.
  - 3. hold: all ex_* outputs keep their value and no bubble is counted.
  - 4. load_use: bubble.
  - 5. Otherwise load: ex_valid<=id_valid; control bits <= id_* ANDed with id_valid; data and field outputs <= captured values.
- Bubble: ex_valid, ex_reg_write, ex_mem_read and ex_mem_write go to 0, and ex_ctrl goes to 0. ex_pc, ex_imm, ex_rs_data, ex_rt_data, ex_rs, ex_rt and ex_dest also go to 0.
  - bubble_cnt increments by 1 on each bubble and saturates at all-ones.
  - A flush counts as a bubble only when id_valid=1.
- A load-use stall lasts exactly one cycle: the bubble clears ex_mem_read, and the held decode instruction loads on the next cycle.
  - During that next cycle the load has reached MEM, so the consumer gets its value from EX forwarding, not from this block.
- flush and hold together: flush wins, the register becomes a bubble, and stall_out=1 because of hold.
- A load with ex_dest==0 never stalls.
- Back-to-back loads to the same register stall once per dependent consumer.
- Reset in the middle of a stall: the next cycle shows ex_valid=0 and stall_out=0, and no bubble is counted.

Test Plan:
- Reset: rst_n=0 for 2 cycles with id inputs randomised -> all ex_* = 0, bubble_cnt=0, stall_out=0.
- Plain load: id_valid=1, rs=2, rt=3, rs_data=0x11, rt_data=0x22, reg_dst=1, rd=5, imm=0xFFFFFFF0 -> next cycle ex_rs_data=0x11, ex_rt_data=0x22, ex_dest=5, ex_valid=1, stall_out=0.
- WB bypass: id_rs=3, id_rs_data=0, wb_reg_write=1, wb_write_reg=3, wb_write_data=0xABCDEF12 -> ex_rs_data=0xABCDEF12. Repeat with wb_write_reg=0 and id_rs=0 -> ex_rs_data=0.
- Load-use: lw with dest 4 in EX (ex_mem_read=1), id add uses rs=4 -> stall_out=1 for one cycle, a bubble follows (ex_valid=0), bubble_cnt=1, and the add loads on the next cycle. Same stimulus with id_uses_rs=0 -> no stall.
- Hold: set hold=1 for 3 cycles while id inputs change -> ex_* unchanged, stall_out=1, bubble_cnt unchanged. Release -> the current id instruction loads.
- Flush plus hold, and saturation: flush=1 with hold=1 -> bubble and stall_out=1. Force 2^CNT_W+3 bubbles -> bubble_cnt stays at 0xFFFF.
